y_zigzag_rle: RTL and testbench

Consumes the 8x8 block of 11-bit signed quantized luminance coefficients produced by the Y quantizer. Reorders the block into zigzag order and DC-differences it against the previous block. Run-length codes the AC coefficients into JPEG (run, size, amplitude) symbols. Symbols go out one per valid/ready handshake to the downstream Huffman encoder.

---
 rtl/y_zigzag_rle.sv | 207 ++++++++++++++++++++
 tb/tb_y_zigzag_rle.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/y_zigzag_rle.sv
// y_zigzag_rle: zigzag reorder, DC prediction and JPEG run-length symbol
// generation for one 8x8 luminance block, one symbol per valid/ready beat.
module y_zigzag_rle #(
  parameter int DATA_W = 11,
  parameter int RUN_W  = 4,
  parameter int SIZE_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [7:0][7:0][DATA_W-1:0]   Q,
  input  logic                          dc_reset,
  output logic                          block_ready,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic [RUN_W-1:0]              sym_run,
  output logic [SIZE_W-1:0]             sym_size,
  output logic [DATA_W-1:0]             sym_amp,
  output logic                          sym_is_dc,
  output logic                          sym_eob,
  output logic                          sym_last,
  output logic                          err_overflow
);

  localparam int DW = DATA_W + 1;

  // Natural (row*8+col) position of each zigzag index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [2:0] {IDLE, DC, SCAN, ZRL, EMIT, EOB, DONE} state_t;

  function automatic logic [SIZE_W-1:0] mag_size(input logic signed [DW-1:0] v);
    logic [DW-1:0]     mag;
    logic [SIZE_W-1:0] sz;
    mag = v[DW-1] ? -v : v;
    sz  = '0;
    for (int b = 0; b < DW; b++) begin
      if (mag[b]) sz = SIZE_W'(b + 1);
      else        sz = sz;
    end
    return sz;
  endfunction

  // Negative values carry the ones-complement of |v| in the low size bits.
  function automatic logic [DATA_W-1:0] mag_amp(input logic signed [DW-1:0] v,
                                                input logic [SIZE_W-1:0]   sz);
    logic [DW-1:0] raw;
    logic [DW-1:0] mask;
    raw  = v[DW-1] ? (v - DW'(1'b1)) : v;
    mask = (DW'(1'b1) << sz) - DW'(1'b1);
    return DATA_W'(raw & mask);
  endfunction

  state_t                      state, state_nxt;
  logic [7:0][7:0][DATA_W-1:0] coef;
  logic signed [DATA_W-1:0]    pred;
  logic [5:0]                  k;
  logic [5:0]                  run;
  logic [5:0]                  pos;
  logic signed [DW-1:0]        cur;
  logic signed [DW-1:0]        diff;
  logic                        capture, hs, cur_zero, last_k;
  logic                        ld, n_dc, n_eob, n_last;
  logic [RUN_W-1:0]            n_run;
  logic [SIZE_W-1:0]           n_size;
  logic [DATA_W-1:0]           n_amp;

  assign pos      = ZZ[k];
  assign cur      = {coef[pos[5:3]][pos[2:0]][DATA_W-1], coef[pos[5:3]][pos[2:0]]};
  assign diff     = {coef[0][0][DATA_W-1], coef[0][0]} - {pred[DATA_W-1], pred};
  assign capture  = enable && block_ready;
  assign hs       = sym_valid && sym_ready;
  assign cur_zero = (cur == '0);
  assign last_k   = (k == 6'd63);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture) state_nxt = DC;   else state_nxt = IDLE;
      DC:   if (hs)      state_nxt = SCAN; else state_nxt = DC;
      SCAN: begin
        if (cur_zero) begin
          if (last_k) state_nxt = EOB;
          else        state_nxt = SCAN;
        end else if (run >= 6'd16) begin
          state_nxt = ZRL;
        end else begin
          state_nxt = EMIT;
        end
      end
      ZRL:  if (hs) state_nxt = SCAN; else state_nxt = ZRL;
      EMIT: if (hs) state_nxt = sym_last ? DONE : SCAN; else state_nxt = EMIT;
      EOB:  if (hs) state_nxt = DONE; else state_nxt = EOB;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Symbol to load into the output registers; loads only when the slot is empty.
  always_comb begin
    ld     = 1'b0;
    n_run  = '0;
    n_size = '0;
    n_amp  = '0;
    n_dc   = 1'b0;
    n_eob  = 1'b0;
    n_last = 1'b0;
    case (state)
      DC: begin
        if (!sym_valid) begin
          ld     = 1'b1;
          n_dc   = 1'b1;
          n_size = mag_size(diff);
          n_amp  = mag_amp(diff, n_size);
        end else begin
          ld = 1'b0;
        end
      end
      SCAN: begin
        if (cur_zero) begin
          ld     = last_k;
          n_eob  = last_k;
          n_last = last_k;
        end else if (run >= 6'd16) begin
          ld    = 1'b1;
          n_run = RUN_W'(4'd15);
        end else begin
          ld     = 1'b1;
          n_run  = RUN_W'(run);
          n_size = mag_size(cur);
          n_amp  = mag_amp(cur, n_size);
          n_last = last_k;
        end
      end
      default: ld = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      block_ready  <= 1'b1;
      err_overflow <= 1'b0;
      sym_valid    <= 1'b0;
      sym_run      <= '0;
      sym_size     <= '0;
      sym_amp      <= '0;
      sym_is_dc    <= 1'b0;
      sym_eob      <= 1'b0;
      sym_last     <= 1'b0;
      pred         <= '0;
      coef         <= '0;
      k            <= 6'd0;
      run          <= 6'd0;
    end else begin
      block_ready <= (state_nxt == IDLE);
      if (enable && !block_ready) err_overflow <= 1'b1;
      if (capture) coef <= Q;
      if (dc_reset)                      pred <= '0;
      else if (state == DC && !sym_valid) pred <= coef[0][0];
      if (ld) begin
        sym_valid <= 1'b1;
        sym_run   <= n_run;
        sym_size  <= n_size;
        sym_amp   <= n_amp;
        sym_is_dc <= n_dc;
        sym_eob   <= n_eob;
        sym_last  <= n_last;
      end else if (hs) begin
        sym_valid <= 1'b0;
      end
      // Zero runs are accumulated here; ZRL symbols consume 16 while k holds.
      case (state)
        IDLE: begin
          k   <= 6'd1;
          run <= 6'd0;
        end
        SCAN: begin
          if (cur_zero) begin
            run <= run + 6'd1;
            if (!last_k) k <= k + 6'd1;
          end else if (run >= 6'd16) begin
            run <= run - 6'd16;
          end else begin
            run <= 6'd0;
          end
        end
        EMIT: if (hs && !sym_last) k <= k + 6'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y_zigzag_rle.sv
// Self-checking bench for y_zigzag_rle: directed plan cases plus random blocks
// compared against a diagonal-walk zigzag / run-length reference model.
module tb_y_zigzag_rle;

  logic                   clk = 1'b0;
  logic                   rst, enable, dc_reset, sym_ready;
  logic [7:0][7:0][10:0]  q_in;
  logic                   block_ready, sym_valid, sym_is_dc, sym_eob, sym_last, err_overflow;
  logic [3:0]             sym_run, sym_size;
  logic [10:0]            sym_amp;

  int vectors = 0;
  int miscompares = 0;
  int blk[64];
  int pred_m = 0;
  logic [21:0] exp_q[$];
  logic [21:0] obs_q[$];

  y_zigzag_rle dut (
    .clk(clk), .rst(rst), .enable(enable), .Q(q_in), .dc_reset(dc_reset),
    .block_ready(block_ready), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
    .sym_is_dc(sym_is_dc), .sym_eob(sym_eob), .sym_last(sym_last),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] pack(input bit d, input bit e, input bit l,
                                       input int r, input int s, input int a);
    return {d, e, l, 4'(r), 4'(s), 11'(a)};
  endfunction

  function automatic logic [21:0] obs_pack();
    return {sym_is_dc, sym_eob, sym_last, sym_run, sym_size, sym_amp};
  endfunction

  function automatic logic [21:0] obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    else return 22'h3FFFFF;
  endfunction

  function automatic int sz_of(input int v);
    int m = (v < 0) ? -v : v;
    int s = 0;
    while (m > 0) begin s++; m = m >> 1; end
    return s;
  endfunction

  function automatic int amp_of(input int v);
    int s = sz_of(v);
    return (v >= 0) ? v : ((v - 1) & ((1 << s) - 1));
  endfunction

  // Reference: walk anti-diagonals for zigzag, then JPEG run-length rules.
  task automatic build_model(input bit dcr);
    int zz[64];
    int n = 0;
    int run = 0;
    int diff;
    exp_q.delete();
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int i = (s < 7 ? s : 7); i >= 0 && i >= s - 7; i--) begin zz[n] = blk[i*8 + s - i]; n++; end
      end else begin
        for (int i = (s > 7 ? s - 7 : 0); i <= 7 && i <= s; i++) begin zz[n] = blk[i*8 + s - i]; n++; end
      end
    end
    if (dcr) pred_m = 0;
    diff = zz[0] - pred_m;
    pred_m = zz[0];
    exp_q.push_back(pack(1, 0, 0, 0, sz_of(diff), amp_of(diff)));
    for (int kk = 1; kk < 64; kk++) begin
      if (zz[kk] == 0) run++;
      else begin
        while (run >= 16) begin exp_q.push_back(pack(0, 0, 0, 15, 0, 0)); run -= 16; end
        exp_q.push_back(pack(0, 0, kk == 63, run, sz_of(zz[kk]), amp_of(zz[kk])));
        run = 0;
      end
    end
    if (zz[63] == 0) exp_q.push_back(pack(0, 1, 1, 0, 0, 0));
  endtask

  task automatic drive_blk();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) q_in[i][j] = 11'(blk[i*8 + j]);
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low 5 cycles at first ZRL.
  task automatic do_block(input bit dcr, input int mode, input int ovf_at);
    logic [21:0] cur, held;
    bit stalled = 0, done = 0, zrl_seen = 0, rdy;
    int stall_left = 0, cyc = 0, w = 0;
    build_model(dcr);
    obs_q.delete();
    held = '0;
    drive_blk();
    enable = 1'b1; dc_reset = dcr; sym_ready = 1'b0;
    @(posedge clk); #1;
    enable = 1'b0; dc_reset = 1'b0;
    chk("ready_drop", 32'(block_ready), 32'd0);
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      enable = 1'b0;
      cur = obs_pack();
      if (cyc == 1) chk("dc_latency", 32'(sym_valid), 32'd1);
      if (stalled) begin
        chk("stall_valid", 32'(sym_valid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(held));
      end
      if (cyc == ovf_at) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++) q_in[i][j] = 11'($urandom_range(1, 2047));
        enable = 1'b1;
      end
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (mode == 2) begin
        if (!zrl_seen && sym_valid && sym_run == 4'd15 && sym_size == 4'd0 && !sym_eob) begin
          zrl_seen = 1; stall_left = 5;
        end
        if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      end
      sym_ready = rdy;
      stalled = sym_valid && !rdy;
      held = cur;
      if (sym_valid && rdy) begin
        obs_q.push_back(cur);
        if (sym_last) done = 1;
      end
    end
    chk("block_done", 32'(done), 32'd1);
    sym_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_last_valid", 32'(sym_valid), 32'd0);
    while (!block_ready && w < 6) begin @(posedge clk); #1; w++; end
    chk("ready_return", 32'(block_ready), 32'd1);
    chk("sym_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk("sym", 32'(obs_at(i)), 32'(exp_q[i]));
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  initial begin
    int bad, dens;
    rst = 1'b1; enable = 1'b0; dc_reset = 1'b0; sym_ready = 1'b0; q_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_block_ready", 32'(block_ready), 32'd1);
    chk("rst_valid", 32'(sym_valid), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    chk("rst_fields", 32'(obs_pack()), 32'd0);
    rst = 1'b0;

    // 1: all-zero block
    clear_blk();
    do_block(1'b0, 0, 0);
    chk("t1_dc", 32'(obs_at(0)), 32'(pack(1, 0, 0, 0, 0, 0)));
    chk("t1_eob", 32'(obs_at(1)), 32'(pack(0, 1, 1, 0, 0, 0)));

    // 2: DC differencing across blocks
    blk[0] = 5;
    do_block(1'b0, 0, 0);
    chk("t2_a_dc", 32'(obs_at(0)), 32'(pack(1, 0, 0, 0, 3, 5)));
    blk[0] = 3;
    do_block(1'b0, 0, 0);
    chk("t2_b_dc", 32'(obs_at(0)), 32'(pack(1, 0, 0, 0, 2, 1)));

    // 3/4: long run ending on a nonzero k=63, then with stall during ZRLs
    clear_blk();
    blk[1] = 1; blk[63] = -1;
    do_block(1'b1, 0, 0);
    chk("t3_first_ac", 32'(obs_at(1)), 32'(pack(0, 0, 0, 0, 1, 1)));
    chk("t3_zrl", 32'(obs_at(2)), 32'(pack(0, 0, 0, 15, 0, 0)));
    chk("t3_last", 32'(obs_at(5)), 32'(pack(0, 0, 1, 13, 1, 0)));
    do_block(1'b1, 2, 0);
    chk("t4_last", 32'(obs_at(5)), 32'(pack(0, 0, 1, 13, 1, 0)));

    // 5: overflow while busy, sticky until reset
    do_block(1'b1, 0, 3);
    chk("t5_err", 32'(err_overflow), 32'd1);
    clear_blk();
    do_block(1'b0, 0, 0);
    chk("t5_err_sticky", 32'(err_overflow), 32'd1);

    // mid-block reset abandons the block
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 20)) - 10;
    drive_blk();
    enable = 1'b1; sym_ready = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    bad = 0;
    repeat (12) begin @(posedge clk); #1; if (sym_valid) bad++; end
    chk("rst_mid_quiet", 32'(bad), 32'd0);
    chk("rst_mid_ready", 32'(block_ready), 32'd1);
    chk("rst_mid_err", 32'(err_overflow), 32'd0);
    pred_m = 0;

    // 6: dc_reset with enable, extreme DC
    clear_blk();
    blk[0] = 100;
    do_block(1'b0, 0, 0);
    blk[0] = -1024;
    do_block(1'b1, 0, 0);
    chk("t6_dc_min", 32'(obs_at(0)), 32'(pack(1, 0, 0, 0, 11, 1023)));
    blk[0] = 0;
    do_block(1'b0, 0, 0);
    chk("t6_next_dc", 32'(obs_at(0)), 32'(pack(1, 0, 0, 0, 11, 1024)));

    // random blocks with random backpressure
    for (int n = 0; n < 24; n++) begin
      dens = int'($urandom_range(1, 12));
      for (int i = 0; i < 64; i++)
        blk[i] = (int'($urandom_range(0, 63)) < dens) ? int'($urandom_range(0, 2046)) - 1023 : 0;
      blk[0] = int'($urandom_range(0, 2047)) - 1024;
      do_block($urandom_range(0, 7) == 0, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
